// File: rtl/mvu_stream_ctrl_if.sv
// Handshake and datapath-control bundle between mvu_stream_ctrl and the MVU stream datapath.
// master = sequencer side, slave = datapath/stream environment side.
interface mvu_stream_ctrl_if #(
    parameter int SF_W = 1,   // buffer address width
    parameter int WM_W = 1    // weight memory address width
) ();

    logic            in_v;
    logic            in_rdy;
    logic            buf_wr_en;
    logic [SF_W-1:0] buf_addr;
    logic            buf_sel;
    logic [WM_W-1:0] wmem_addr;
    logic            pipe_en;
    logic            acc_clr;
    logic            acc_last;
    logic            out_v;
    logic            out_rdy;

    modport master (
        input  in_v,
        input  out_rdy,
        output in_rdy,
        output buf_wr_en,
        output buf_addr,
        output buf_sel,
        output wmem_addr,
        output pipe_en,
        output acc_clr,
        output acc_last,
        output out_v
    );

    modport slave (
        output in_v,
        output out_rdy,
        input  in_rdy,
        input  buf_wr_en,
        input  buf_addr,
        input  buf_sel,
        input  wmem_addr,
        input  pipe_en,
        input  acc_clr,
        input  acc_last,
        input  out_v
    );

endinterface

// File: rtl/mvu_stream_ctrl.sv
// MVU stream sequencer: walks SF/NF folds, drives buffer/weight addressing and accumulator strobes.
// Optional MVU_CTRL_PERF_CNT_EN adds saturating issue/stall/starve performance counters.
module mvu_stream_ctrl #(
    parameter int MatrixW  = 64,
    parameter int MatrixH  = 32,
    parameter int SIMD     = 8,
    parameter int PE       = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mvu_stream_ctrl_if.master   bus
`ifdef MVU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_starve_cnt
`endif
);

    localparam int SF         = MatrixW / SIMD;
    localparam int NF         = MatrixH / PE;
    localparam int WMEM_DEPTH = SF * NF;
    localparam int SF_W       = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W       = (NF > 1) ? $clog2(NF) : 1;
    localparam int WM_W       = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_REUSE = 1'b1;

    localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);
    localparam logic [WM_W-1:0] WM_MAX = WM_W'(WMEM_DEPTH - 1);
    localparam logic            MULTI_NF = (NF > 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [SF_W-1:0]     r_sf_cnt;
    logic [NF_W-1:0]     r_nf_cnt;
    logic [WM_W-1:0]     r_wm_cnt;
    logic [PIPE_LAT-1:0] r_res_pipe;

    logic w_fill;
    logic w_out_v;
    logic w_stall;
    logic w_issue;
    logic w_sf_first;
    logic w_sf_last;
    logic w_nf_last;
    logic w_vec_done;

    // ------------------------------------------------------------------
    // Issue / stall decode
    // ------------------------------------------------------------------
    assign w_fill     = (r_state == ST_FILL);
    assign w_out_v    = r_res_pipe[PIPE_LAT-1];
    assign w_stall    = w_out_v & ~bus.out_rdy;
    assign w_sf_first = (r_sf_cnt == '0);
    assign w_sf_last  = (r_sf_cnt == SF_MAX);
    assign w_nf_last  = (r_nf_cnt == NF_MAX);
    assign w_vec_done = w_issue & w_sf_last & w_nf_last;

    // rst_n gates the strobes so every output reads 0 while reset is held.
    assign w_issue = rst_n & ~w_stall & (w_fill ? bus.in_v : 1'b1);

    assign bus.in_rdy    = rst_n & w_fill & ~w_stall;
    assign bus.pipe_en   = rst_n & ~w_stall;
    assign bus.buf_wr_en = w_issue & w_fill;
    assign bus.buf_sel   = ~w_fill;
    assign bus.acc_clr   = w_issue & w_sf_first;
    assign bus.acc_last  = w_issue & w_sf_last;
    assign bus.out_v     = w_out_v;
    assign bus.buf_addr  = w_issue ? r_sf_cnt : '0;
    assign bus.wmem_addr = w_issue ? r_wm_cnt : '0;

    // ------------------------------------------------------------------
    // Fold counters. r_wm_cnt walks linearly in step with the folds, so it
    // always equals nf_cnt*SF + sf_cnt without needing a multiplier.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sf_cnt <= '0;
            r_nf_cnt <= '0;
            r_wm_cnt <= '0;
        end else if (w_issue) begin
            if (w_sf_last) begin
                r_sf_cnt <= '0;
                r_nf_cnt <= w_nf_last ? '0 : r_nf_cnt + 1'b1;
            end else begin
                r_sf_cnt <= r_sf_cnt + 1'b1;
            end
            r_wm_cnt <= (r_wm_cnt == WM_MAX) ? '0 : r_wm_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FILL consumes the live stream for the first neuron fold; REUSE
    // replays the buffer for the remaining folds.
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this combinational block
    // from inferring a latch on paths that do not change state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_issue & w_sf_last & (r_nf_cnt == '0) & MULTI_NF)
                    w_state_nxt = ST_REUSE;
            end
            ST_REUSE: begin
                if (w_vec_done)
                    w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Result tracking: one tag per last-chunk issue, moving with pipe_en.
    // A consumed result shifts out in the same cycle a new one may land.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_pipe <= '0;
        end else if (!w_stall) begin
            r_res_pipe <= PIPE_LAT'({r_res_pipe, (w_issue & w_sf_last)});
        end
    end

`ifdef MVU_CTRL_PERF_CNT_EN
    logic w_starve;
    assign w_starve = rst_n & w_fill & ~bus.in_v & ~w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt  <= '0;
            perf_stall_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (w_issue  && (perf_issue_cnt  != '1)) perf_issue_cnt  <= perf_issue_cnt  + 1'b1;
            if (w_stall  && (perf_stall_cnt  != '1)) perf_stall_cnt  <= perf_stall_cnt  + 1'b1;
            if (w_starve && (perf_starve_cnt != '1)) perf_starve_cnt <= perf_starve_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mvu_stream_ctrl.sv
// Self-checking bench for mvu_stream_ctrl: directed and random steps against a fold-level model.
// DUT A: SF=4, NF=2, PIPE_LAT=2.  DUT B: SF=1, NF=1.  Perf checks when MVU_CTRL_PERF_CNT_EN is set.
module tb_mvu_stream_ctrl;

    localparam int PIPE_LAT = 2;
    localparam int MW_A = 8, SIMD_A = 2, MH_A = 4, PE_A = 2;
    localparam int SF_A = MW_A / SIMD_A;
    localparam int NF_A = MH_A / PE_A;
    localparam int MW_B = 2, SIMD_B = 2, MH_B = 2, PE_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvu_stream_ctrl_if #(.SF_W(2), .WM_W(3)) bus_a ();
    mvu_stream_ctrl_if #(.SF_W(1), .WM_W(1)) bus_b ();

`ifdef MVU_CTRL_PERF_CNT_EN
    logic [31:0] pa_issue, pa_stall, pa_starve;
    logic [31:0] pb_issue, pb_stall, pb_starve;
`endif

    mvu_stream_ctrl #(
        .MatrixW(MW_A), .MatrixH(MH_A), .SIMD(SIMD_A), .PE(PE_A), .PIPE_LAT(PIPE_LAT)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
`ifdef MVU_CTRL_PERF_CNT_EN
        , .perf_issue_cnt(pa_issue), .perf_stall_cnt(pa_stall), .perf_starve_cnt(pa_starve)
`endif
    );

    mvu_stream_ctrl #(
        .MatrixW(MW_B), .MatrixH(MH_B), .SIMD(SIMD_B), .PE(PE_B), .PIPE_LAT(PIPE_LAT)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
`ifdef MVU_CTRL_PERF_CNT_EN
        , .perf_issue_cnt(pb_issue), .perf_stall_cnt(pb_stall), .perf_starve_cnt(pb_starve)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model A: position within the vector (chunk index k = nf*SF + sf) and
    // the remaining enabled-cycle delay of each result still in flight.
    int ka = 0;
    int pend_a[$];
    int exp_issue_a = 0, exp_stall_a = 0, exp_starve_a = 0;
    // Model B: SF=NF=1, so every accepted input becomes a result PIPE_LAT cycles later.
    bit hist_b[$];

    int n_in_a = 0, n_out_a = 0, n_in_b = 0, n_out_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string who);
        check({who, "_rst_in_rdy"}, {31'd0, bus_a.in_rdy | bus_b.in_rdy}, 32'd0);
        check({who, "_rst_pipe_en"}, {31'd0, bus_a.pipe_en | bus_b.pipe_en}, 32'd0);
        check({who, "_rst_wr_en"}, {31'd0, bus_a.buf_wr_en | bus_b.buf_wr_en}, 32'd0);
        check({who, "_rst_buf_sel"}, {31'd0, bus_a.buf_sel | bus_b.buf_sel}, 32'd0);
        check({who, "_rst_acc"}, {30'd0, bus_a.acc_clr | bus_b.acc_clr, bus_a.acc_last | bus_b.acc_last}, 32'd0);
        check({who, "_rst_out_v"}, {31'd0, bus_a.out_v | bus_b.out_v}, 32'd0);
        check({who, "_rst_wmem"}, {29'd0, bus_a.wmem_addr}, 32'd0);
        check({who, "_rst_baddr"}, {30'd0, bus_a.buf_addr}, 32'd0);
`ifdef MVU_CTRL_PERF_CNT_EN
        check({who, "_rst_perf"}, pa_issue | pa_stall | pa_starve, 32'd0);
`endif
    endtask

    // Assert reset with inputs active (strobes must still read 0), then release
    // just after a posedge so the next step() starts a fresh modelled cycle.
    task automatic do_reset(input string who);
        @(negedge clk);
        bus_a.in_v = 1'b1; bus_a.out_rdy = 1'b1;
        bus_b.in_v = 1'b1; bus_b.out_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(who);
        repeat (2) @(posedge clk);
        #1;
        bus_a.in_v = 1'b0; bus_b.in_v = 1'b0;
        rst_n = 1'b1;
        ka = 0;
        pend_a.delete();
        hist_b.delete();
        exp_issue_a = 0; exp_stall_a = 0; exp_starve_a = 0;
    endtask

    task automatic step(input logic iv_a, input logic rdy_a, input logic iv_b);
        logic e_outv, e_stall, e_fill, e_issue, e_last, e_outv_b;
        int sf;
        @(negedge clk);
        bus_a.in_v = iv_a; bus_a.out_rdy = rdy_a;
        bus_b.in_v = iv_b; bus_b.out_rdy = 1'b1;
        #1;
        e_outv  = (pend_a.size() > 0) && (pend_a[0] == 0);
        e_stall = e_outv & ~rdy_a;
        e_fill  = (ka < SF_A);
        e_issue = ~e_stall & (e_fill ? iv_a : 1'b1);
        sf      = ka % SF_A;
        e_last  = (sf == SF_A - 1);

        check("a_out_v",   {31'd0, bus_a.out_v},     {31'd0, e_outv});
        check("a_pipe_en", {31'd0, bus_a.pipe_en},   {31'd0, ~e_stall});
        check("a_in_rdy",  {31'd0, bus_a.in_rdy},    {31'd0, e_fill & ~e_stall});
        check("a_wr_en",   {31'd0, bus_a.buf_wr_en}, {31'd0, e_issue & e_fill});
        check("a_buf_sel", {31'd0, bus_a.buf_sel},   {31'd0, ~e_fill});
        check("a_acc_clr", {31'd0, bus_a.acc_clr},   {31'd0, e_issue & (sf == 0)});
        check("a_acc_last",{31'd0, bus_a.acc_last},  {31'd0, e_issue & e_last});
        check("a_wmem",    {29'd0, bus_a.wmem_addr}, e_issue ? 32'(ka) : 32'd0);
        check("a_buf_addr",{30'd0, bus_a.buf_addr},  e_issue ? 32'(sf) : 32'd0);
`ifdef MVU_CTRL_PERF_CNT_EN
        check("a_perf_issue",  pa_issue,  32'(exp_issue_a));
        check("a_perf_stall",  pa_stall,  32'(exp_stall_a));
        check("a_perf_starve", pa_starve, 32'(exp_starve_a));
`endif
        if (bus_a.in_v && bus_a.in_rdy) n_in_a++;
        if (bus_a.out_v && bus_a.out_rdy) n_out_a++;

        if (!e_stall) begin
            if (e_outv) void'(pend_a.pop_front());
            foreach (pend_a[i]) pend_a[i] = pend_a[i] - 1;
            if (e_issue && e_last) pend_a.push_back(PIPE_LAT - 1);
        end
        if (e_issue) begin
            ka = (ka + 1) % (SF_A * NF_A);
            exp_issue_a++;
        end
        if (e_stall) exp_stall_a++;
        if (e_fill && !iv_a && !e_stall) exp_starve_a++;

        e_outv_b = (hist_b.size() >= PIPE_LAT) ? hist_b[hist_b.size() - PIPE_LAT] : 1'b0;
        check("b_out_v",   {31'd0, bus_b.out_v},    {31'd0, e_outv_b});
        check("b_in_rdy",  {31'd0, bus_b.in_rdy},   32'd1);
        check("b_acc",     {30'd0, bus_b.acc_clr, bus_b.acc_last}, {30'd0, iv_b, iv_b});
        check("b_wr_en",   {31'd0, bus_b.buf_wr_en}, {31'd0, iv_b});
        check("b_buf_sel", {31'd0, bus_b.buf_sel},  32'd0);
        if (bus_b.in_v && bus_b.in_rdy) n_in_b++;
        if (bus_b.out_v) n_out_b++;
        hist_b.push_back(iv_b);
        if (hist_b.size() > PIPE_LAT) void'(hist_b.pop_front());
    endtask

    // Finish the current vector with continuous traffic, then let results drain.
    task automatic drain(input string who);
        int guard;
        guard = 0;
        while (ka != 0 && guard < 64) begin
            step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check({who, "_drain_bound"}, {31'd0, (guard >= 64)}, 32'd0);
        repeat (PIPE_LAT + 2) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int guard;
        bus_a.in_v = 1'b0; bus_a.out_rdy = 1'b1;
        bus_b.in_v = 1'b0; bus_b.out_rdy = 1'b1;

        do_reset("init");

        // Continuous traffic: one full vector.
        n_in_a = 0; n_out_a = 0;
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("t1_in_handshakes", 32'(n_in_a), 32'd4);
        check("t1_outputs", 32'(n_out_a), 32'd2);

        // Downstream back-pressure on the first result: three stalled cycles.
        n_out_a = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        drain("t2");
        check("t2_outputs", 32'(n_out_a), 32'd2);
`ifdef MVU_CTRL_PERF_CNT_EN
        check("t2_perf_issue", pa_issue, 32'd16);
        check("t2_perf_stall", pa_stall, 32'd3);
`endif

        // Toggling input valid: bubbles in FILL, REUSE runs back to back.
        n_out_a = 0;
        for (int i = 0; i < 12; i++) step((i % 2) == 0, 1'b1, 1'b0);
        drain("t3");
        check("t3_outputs", 32'(n_out_a), 32'd2);

        // Reset in REUSE at sf=2 (k = SF + 2), then restart from FILL at address 0.
        guard = 0;
        while (ka != SF_A + 2 && guard < 32) begin
            step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("t4_reach_bound", {31'd0, (guard >= 32)}, 32'd0);
        do_reset("t4");
        n_in_a = 0; n_out_a = 0;
        repeat (8) step(1'b1, 1'b1, 1'b0);
        drain("t4");
        check("t4_in_handshakes", 32'(n_in_a), 32'd4);
        check("t4_outputs", 32'(n_out_a), 32'd2);

        // SF=NF=1 instance: one result per accepted input.
        n_in_b = 0; n_out_b = 0;
        repeat (24) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        repeat (PIPE_LAT + 2) step(1'b0, 1'b1, 1'b0);
        check("t5_outputs_eq_inputs", 32'(n_out_b), 32'(n_in_b));

        // Random valid/ready traffic on both instances.
        repeat (300) step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
